bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 107 ++++++++++
 tb/tb_bcd_updown_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Cascadable BCD up/down counter with parallel load.
// It supports wrap or saturate at the limit, and registered overflow and load-error pulses.
module bcd_updown_counter #(
    parameter int DIGITS      = 3,
    parameter int SAT_DEFAULT = 0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    input  logic                  SatMode,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Tc,
    output logic                  Ovf,
    output logic                  LoadErr,
    output logic                  Zero
);

    localparam int W = 4 * DIGITS;

    // Reject illegal parameterisations at elaboration time.
    if (DIGITS < 1 || DIGITS > 8 || SAT_DEFAULT < 0 || SAT_DEFAULT > 1) begin : g_param_check
        $error("bcd_updown_counter: illegal DIGITS or SAT_DEFAULT");
    end

    logic [W-1:0] count_q;
    logic [W-1:0] count_step;
    logic [W-1:0] load_clean;
    logic         load_bad;
    logic         all9;
    logic         all0;
    logic         limit;
    logic         ovf_q;
    logic         lerr_q;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all9 = all9 & (count_q[4*i +: 4] == 4'd9);
            all0 = all0 & (count_q[4*i +: 4] == 4'd0);
        end
    end

    // Carry/borrow look-through: a digit moves only when every lower digit is at its edge value.
    always_comb begin
        logic run;
        run        = 1'b1;
        count_step = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (run) begin
                if (Up) begin
                    count_step[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ?
                        4'd0 : count_q[4*i +: 4] + 4'd1;
                end else begin
                    count_step[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ?
                        4'd9 : count_q[4*i +: 4] - 4'd1;
                end
            end
            run = run & (Up ? (count_q[4*i +: 4] == 4'd9) :
                              (count_q[4*i +: 4] == 4'd0));
        end
    end

    always_comb begin
        load_clean = LoadValue;
        load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (LoadValue[4*i +: 4] > 4'd9) begin
                load_clean[4*i +: 4] = 4'd9;
                load_bad             = 1'b1;
            end
        end
    end

    assign limit = Up ? all9 : all0;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else if (Load) begin
            count_q <= load_clean;
            ovf_q   <= 1'b0;
            lerr_q  <= load_bad;
        end else if (Enable) begin
            if (!(limit && SatMode)) begin
                count_q <= count_step;
            end
            ovf_q  <= limit;
            lerr_q <= 1'b0;
        end else begin
            ovf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end
    end

    assign Count   = count_q;
    assign Ovf     = ovf_q;
    assign LoadErr = lerr_q;
    assign Tc      = Enable & limit;
    assign Zero    = all0;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: vector table, model-driven sequences
// and a two-digit cascade compared against a four-digit instance.
module tb_bcd_updown_counter;

    localparam int D    = 3;
    localparam int W    = 4 * D;
    localparam int MAXV = 999;

    logic         Clock = 1'b0;
    logic         nReset;
    logic         Enable;
    logic         Up;
    logic         Load;
    logic         SatMode;
    logic [W-1:0] LoadValue;
    logic [W-1:0] Count;
    logic         Tc;
    logic         Ovf;
    logic         LoadErr;
    logic         Zero;

    always #5 Clock = ~Clock;

    bcd_updown_counter #(.DIGITS(D), .SAT_DEFAULT(0)) dut (
        .Clock(Clock), .nReset(nReset), .Enable(Enable), .Up(Up),
        .Load(Load), .LoadValue(LoadValue), .SatMode(SatMode),
        .Count(Count), .Tc(Tc), .Ovf(Ovf), .LoadErr(LoadErr), .Zero(Zero)
    );

    // Cascade: two 2-digit stages versus one 4-digit counter.
    logic        cRst;
    logic        cEn;
    logic        cUp;
    logic [7:0]  loCount;
    logic [7:0]  hiCount;
    logic [15:0] refCount;
    logic        loTc, hiTc, refTc;
    logic        loOvf, hiOvf, refOvf;
    logic        loErr, hiErr, refErr;
    logic        loZero, hiZero, refZero;

    bcd_updown_counter #(.DIGITS(2)) u_lo (
        .Clock(Clock), .nReset(cRst), .Enable(cEn), .Up(cUp),
        .Load(1'b0), .LoadValue(8'h00), .SatMode(1'b0),
        .Count(loCount), .Tc(loTc), .Ovf(loOvf), .LoadErr(loErr), .Zero(loZero)
    );
    bcd_updown_counter #(.DIGITS(2)) u_hi (
        .Clock(Clock), .nReset(cRst), .Enable(loTc), .Up(cUp),
        .Load(1'b0), .LoadValue(8'h00), .SatMode(1'b0),
        .Count(hiCount), .Tc(hiTc), .Ovf(hiOvf), .LoadErr(hiErr), .Zero(hiZero)
    );
    bcd_updown_counter #(.DIGITS(4)) u_ref (
        .Clock(Clock), .nReset(cRst), .Enable(cEn), .Up(cUp),
        .Load(1'b0), .LoadValue(16'h0000), .SatMode(1'b0),
        .Count(refCount), .Tc(refTc), .Ovf(refOvf), .LoadErr(refErr), .Zero(refZero)
    );

    typedef struct {
        logic         rst;
        logic         ld;
        logic         en;
        logic         up;
        logic         sat;
        logic [W-1:0] lv;
        logic [W-1:0] cnt;
        logic         ovf;
        logic         lerr;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic         ovf;
        logic         lerr;
        logic         tc;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   mval   = 0;
    int   ovf_seen;

    function automatic logic [W-1:0] i2b(input int v);
        logic [W-1:0] b;
        int           t;
        b = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    function automatic vec_t mkv(input logic rst, ld, en, up, sat,
                                 input logic [W-1:0] lv, cnt,
                                 input logic ovf, lerr);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.sat = sat;
        v.lv = lv; v.cnt = cnt; v.ovf = ovf; v.lerr = lerr;
        return v;
    endfunction

    function automatic exp_t mke(input logic en, up,
                                 input logic [W-1:0] cnt,
                                 input logic ovf, lerr);
        exp_t e;
        e.cnt  = cnt;
        e.ovf  = ovf;
        e.lerr = lerr;
        e.zero = (cnt == '0);
        e.tc   = en & (up ? (cnt == i2b(MAXV)) : (cnt == '0));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic apply(input logic rst, ld, en, up, sat,
                         input logic [W-1:0] lv, input exp_t e);
        exp_t x;
        @(negedge Clock);
        nReset = rst; Load = ld; Enable = en; Up = up;
        SatMode = sat; LoadValue = lv;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        x = sb.pop_front();
        chk("count", 32'(Count), 32'(x.cnt));
        chk("ovf", 32'(Ovf), 32'(x.ovf));
        chk("loaderr", 32'(LoadErr), 32'(x.lerr));
        chk("tc", 32'(Tc), 32'(x.tc));
        chk("zero", 32'(Zero), 32'(x.zero));
        if (Ovf === 1'b1) ovf_seen++;
    endtask

    // Integer reference model; mval holds the decimal count.
    task automatic apply_m(input logic rst, ld, en, up, sat, input logic [W-1:0] lv);
        logic o, e;
        int   v;
        int   dg;
        o = 1'b0;
        e = 1'b0;
        if (!rst) begin
            mval = 0;
        end else if (ld) begin
            v = 0;
            for (int i = D - 1; i >= 0; i--) begin
                dg = int'(lv[4*i +: 4]);
                if (dg > 9) begin
                    dg = 9;
                    e  = 1'b1;
                end
                v = v * 10 + dg;
            end
            mval = v;
        end else if (en) begin
            if (up && mval == MAXV) begin
                o = 1'b1;
                if (!sat) mval = 0;
            end else if (!up && mval == 0) begin
                o = 1'b1;
                if (!sat) mval = MAXV;
            end else begin
                mval = up ? mval + 1 : mval - 1;
            end
        end
        apply(rst, ld, en, up, sat, lv, mke(en, up, i2b(mval), o, e));
    endtask

    initial begin
        vec_t v;
        int   cval;
        nReset = 1'b0; Load = 1'b0; Enable = 1'b0; Up = 1'b1;
        SatMode = 1'b0; LoadValue = '0;
        cRst = 1'b0; cEn = 1'b0; cUp = 1'b1;

        tbl.push_back(mkv(0,0,0,1,0,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,1,0,1,0,12'h123,12'h123,0,0));
        tbl.push_back(mkv(1,0,1,1,0,12'h000,12'h124,0,0));
        tbl.push_back(mkv(1,0,0,0,0,12'h000,12'h124,0,0));
        tbl.push_back(mkv(1,1,0,1,0,12'h199,12'h199,0,0));
        tbl.push_back(mkv(1,0,1,1,0,12'h000,12'h200,0,0));
        tbl.push_back(mkv(1,1,0,0,0,12'h100,12'h100,0,0));
        tbl.push_back(mkv(1,0,1,0,0,12'h000,12'h099,0,0));
        tbl.push_back(mkv(1,1,0,0,0,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,0,1,0,0,12'h000,12'h999,1,0));
        tbl.push_back(mkv(1,0,0,1,0,12'h000,12'h999,0,0));
        tbl.push_back(mkv(1,0,1,1,0,12'h000,12'h000,1,0));
        tbl.push_back(mkv(1,1,1,1,0,12'hA3F,12'h939,0,1));
        tbl.push_back(mkv(1,0,0,1,0,12'h000,12'h939,0,0));
        tbl.push_back(mkv(1,1,0,1,1,12'h998,12'h998,0,0));
        tbl.push_back(mkv(1,0,1,1,1,12'h000,12'h999,0,0));
        tbl.push_back(mkv(1,0,1,1,1,12'h000,12'h999,1,0));
        tbl.push_back(mkv(1,0,1,1,1,12'h000,12'h999,1,0));
        tbl.push_back(mkv(1,0,1,0,1,12'h000,12'h998,0,0));
        tbl.push_back(mkv(1,1,0,0,1,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,0,1,0,1,12'h000,12'h000,1,0));
        tbl.push_back(mkv(1,0,0,0,1,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,1,0,1,0,12'h999,12'h999,0,0));
        tbl.push_back(mkv(0,0,1,1,0,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,0,0,1,0,12'h000,12'h000,0,0));
        tbl.push_back(mkv(1,1,0,1,0,12'hFFF,12'h999,0,1));
        tbl.push_back(mkv(1,1,0,1,0,12'h5C0,12'h590,0,1));
        tbl.push_back(mkv(0,1,1,1,0,12'h555,12'h000,0,0));
        tbl.push_back(mkv(1,1,0,1,0,12'h909,12'h909,0,0));
        tbl.push_back(mkv(1,0,1,1,0,12'h000,12'h910,0,0));

        foreach (tbl[k]) begin
            v = tbl[k];
            apply(v.rst, v.ld, v.en, v.up, v.sat, v.lv,
                  mke(v.en, v.up, v.cnt, v.ovf, v.lerr));
        end

        // 1000 up edges from reset: one wrap, one Ovf pulse.
        apply_m(0, 0, 0, 1, 0, '0);
        ovf_seen = 0;
        for (int i = 0; i < 1000; i++) apply_m(1, 0, 1, 1, 0, '0);
        chk("ovf_pulses_up", 32'(ovf_seen), 32'd1);

        // Load 500, count down 501 edges through 000 to 999.
        apply_m(1, 1, 0, 0, 0, 12'h500);
        ovf_seen = 0;
        for (int i = 0; i < 501; i++) apply_m(1, 0, 1, 0, 0, '0);
        chk("ovf_pulses_down", 32'(ovf_seen), 32'd1);
        chk("final_999", 32'(Count), 32'h999);

        // Random mix against the model, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            apply_m(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    W'($urandom));
        end

        // Cascade comparison, 10000 random edges.
        @(negedge Clock);
        cRst = 1'b0;
        @(negedge Clock);
        cRst = 1'b1;
        cval = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge Clock);
            cEn = 1'($urandom);
            cUp = ($urandom_range(0, 3) != 0);
            if (cEn) cval = cUp ? (cval + 1) % 10000 : (cval + 9999) % 10000;
            @(posedge Clock);
            #1;
            checks++;
            if ({hiCount, loCount} !== refCount) begin
                errors++;
                $display("FAIL cascade: got %0h want %0h", {hiCount, loCount}, refCount);
            end
            checks++;
            if (refCount !== {4'(cval / 1000), 4'((cval / 100) % 10),
                              4'((cval / 10) % 10), 4'(cval % 10)}) begin
                errors++;
                $display("FAIL ref4: got %0h want %0d", refCount, cval);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
